// File: rtl/conv_scan_controller_if.sv
// ---------------------------------------------------------------------------
// conv_scan_controller_if
// Bundles the pixel-source handshake, the result handshake and the frame
// status signals of conv_scan_controller.
//   master : the environment (pixel source, downstream sink, frame sequencer)
//   slave  : the controller itself
// Signals
//   start      master->slave  begin a frame (sampled only while idle)
//   in_valid   master->slave  pixel present at the source
//   in_ready   slave->master  controller takes a pixel this cycle
//   shift_en   slave->master  pixel accepted this cycle; advances line buffers
//   row, col   slave->master  position of the next pixel to accept
//   out_valid  slave->master  window result valid to the sink
//   out_ready  master->slave  sink accepts the result
//   out_cnt    slave->master  results handed over this frame
//   busy       slave->master  controller not idle
//   done       slave->master  one-cycle end-of-frame pulse
// ---------------------------------------------------------------------------
interface conv_scan_controller_if #(
    parameter int CW = 16
);
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          shift_en;
    logic [CW-1:0] row;
    logic [CW-1:0] col;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] out_cnt;
    logic          busy;
    logic          done;

    modport master (
        output start, in_valid, out_ready,
        input  in_ready, shift_en, row, col, out_valid, out_cnt, busy, done
    );

    modport slave (
        input  start, in_valid, out_ready,
        output in_ready, shift_en, row, col, out_valid, out_cnt, busy, done
    );
endinterface

// File: rtl/conv_scan_controller.sv
// ---------------------------------------------------------------------------
// conv_scan_controller
// Sequences one raster-order frame through the streaming convolution
// datapath: accepts pixels, tracks row/column, pulses the line-buffer shift
// enable and raises a one-deep, backpressured result flag wherever a full
// KxK window has been assembled.
// Ports
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   scan  conv_scan_controller_if.slave (handshakes, position, status)
// ---------------------------------------------------------------------------
module conv_scan_controller #(
    parameter int IMG_W = 32,
    parameter int IMG_H = 32,
    parameter int K     = 3,
    parameter int CW    = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    conv_scan_controller_if.slave  scan
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_FLUSH,
        S_DONE
    } state_e;

    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [CW-1:0] LAST_ROW = CW'(IMG_H - 1);

    state_e        state_q;
    logic [CW-1:0] row_q;
    logic [CW-1:0] col_q;
    logic [CW-1:0] out_cnt_q;
    logic          out_valid_q;
    logic          done_q;

    logic          in_ready;
    logic          accept;
    logic          handoff;
    logic          in_window;

    // The output slot is one deep: a new pixel may enter when the slot is
    // empty or is being emptied in the same cycle.
    assign in_ready = (state_q == S_STREAM) && (!out_valid_q || scan.out_ready);
    assign accept   = in_ready && scan.in_valid;
    assign handoff  = out_valid_q && scan.out_ready;

    // With a 1x1 kernel every position is a window; otherwise the position
    // must be at least K-1 into both dimensions.
    generate
        if (K == 1) begin : g_k1
            assign in_window = 1'b1;
        end else begin : g_kn
            localparam logic [CW-1:0] WIN_MIN = CW'(K - 1);
            assign in_window = (row_q >= WIN_MIN) && (col_q >= WIN_MIN);
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; later assignments in the block override earlier
    // defaults, which is how done_q gets its one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (handoff) begin
                out_cnt_q <= out_cnt_q + 1'b1;
            end

            // A new window result takes priority: if the old one is handed
            // over in the same cycle, the slot simply stays full.
            if (accept && in_window) begin
                out_valid_q <= 1'b1;
            end else if (handoff) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (scan.start) begin
                        row_q     <= '0;
                        col_q     <= '0;
                        out_cnt_q <= '0;
                        state_q   <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (accept) begin
                        if (col_q == LAST_COL) begin
                            col_q <= '0;
                            if (row_q == LAST_ROW) begin
                                row_q   <= '0;
                                state_q <= S_FLUSH;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                S_FLUSH: begin
                    // Leave once the last result is gone or leaving now.
                    if (!out_valid_q || scan.out_ready) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign scan.in_ready  = in_ready;
    assign scan.shift_en  = accept;
    assign scan.row       = row_q;
    assign scan.col       = col_q;
    assign scan.out_valid = out_valid_q;
    assign scan.out_cnt   = out_cnt_q;
    assign scan.busy      = (state_q != S_IDLE);
    assign scan.done      = done_q;

endmodule

// File: tb/tb_conv_scan_controller.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_conv_scan_controller
// Directed bench: DUT a is a 4x4 frame with a 3x3 kernel, DUT b is a 2x2
// frame with a 1x1 kernel. Inputs change 1 ns after the rising edge and
// outputs are sampled on the falling edge. Cycle 0 of a frame is the cycle
// in which start is driven.
// ---------------------------------------------------------------------------
module tb_conv_scan_controller;

    localparam int CW = 16;

    logic clk;
    logic rst;

    int n_checks;
    int n_errors;

    // results of the most recent run_a frame
    int            hs_q[$];
    int            acc_n;
    int            done_n;
    int            done_cyc;
    logic [CW-1:0] cnt_at_done;

    conv_scan_controller_if #(.CW(CW)) a ();
    conv_scan_controller_if #(.CW(CW)) b ();

    conv_scan_controller #(.IMG_W(4), .IMG_H(4), .K(3), .CW(CW)) dut_a (
        .clk  (clk),
        .rst  (rst),
        .scan (a.slave)
    );

    conv_scan_controller #(.IMG_W(2), .IMG_H(2), .K(1), .CW(CW)) dut_b (
        .clk  (clk),
        .rst  (rst),
        .scan (b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame on DUT a with in_valid held high. out_ready is low for
    // stall_len cycles starting at cycle stall_from. During the stall the
    // controller must not take pixels, must not signal done and must keep
    // its position.
    task automatic run_a(input string tag, input int stall_from, input int stall_len,
                         input int e0, input int e1, input int e2, input int e3,
                         input int exp_done);
        int            exp_hs[4];
        logic [CW-1:0] hold_row;
        logic [CW-1:0] hold_col;
        exp_hs = '{e0, e1, e2, e3};
        hs_q.delete();
        acc_n    = 0;
        done_n   = 0;
        done_cyc = -1;
        cnt_at_done = '0;
        hold_row = '0;
        hold_col = '0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            a.start     = (cyc == 0);
            a.in_valid  = 1'b1;
            a.out_ready = !(cyc >= stall_from && cyc < stall_from + stall_len);
            @(negedge clk);
            if (a.shift_en) acc_n++;
            if (a.out_valid && a.out_ready) hs_q.push_back(cyc);
            if (a.done) begin
                done_n++;
                done_cyc    = cyc;
                cnt_at_done = a.out_cnt;
            end
            if (cyc == stall_from) begin
                hold_row = a.row;
                hold_col = a.col;
            end
            if (stall_len > 0 && cyc >= stall_from && cyc < stall_from + stall_len) begin
                check({tag, " stall in_ready"}, a.in_ready, 0);
                check({tag, " stall done"}, a.done, 0);
                check({tag, " stall busy"}, a.busy, 1);
                if (cyc > stall_from) begin
                    check({tag, " stall row"}, a.row, hold_row);
                    check({tag, " stall col"}, a.col, hold_col);
                end
            end
            next_cycle();
            if (done_cyc >= 0 && cyc >= done_cyc + 1) break;
        end
        a.start     = 1'b0;
        a.in_valid  = 1'b0;
        a.out_ready = 1'b1;
        check({tag, " accepts"}, acc_n, 16);
        check({tag, " done pulses"}, done_n, 1);
        check({tag, " done cycle"}, done_cyc, exp_done);
        check({tag, " out_cnt at done"}, cnt_at_done, 4);
        check({tag, " result count"}, hs_q.size(), 4);
        for (int i = 0; i < 4 && i < hs_q.size(); i++) begin
            check({tag, $sformatf(" result %0d cycle", i)}, hs_q[i], exp_hs[i]);
        end
        @(negedge clk);
        check({tag, " busy after frame"}, a.busy, 0);
        next_cycle();
    endtask

    initial begin
        int   hit;
        logic saw_done;
        logic [7:0] exp_sh;
        logic [7:0] exp_ov;
        logic [7:0] exp_dn;
        logic [7:0] start_pat;

        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        a.start = 1'b0; a.in_valid = 1'b0; a.out_ready = 1'b1;
        b.start = 1'b0; b.in_valid = 1'b0; b.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1. idle with in_valid but no start
        a.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1 in_ready", a.in_ready, 0);
            check("t1 shift_en", a.shift_en, 0);
            check("t1 row", a.row, 0);
            check("t1 col", a.col, 0);
            check("t1 busy", a.busy, 0);
            check("t1 out_valid", a.out_valid, 0);
            check("t1 done", a.done, 0);
            next_cycle();
        end
        a.in_valid = 1'b0;

        // 2. free-running frame: accepts in cycles 1..16, results visible the
        //    cycle after accepts 11, 12, 15, 16; FLUSH at 17, done at 18.
        run_a("t2", 1000, 0, 12, 13, 16, 17, 18);

        // 3. sink stalls cycles 12..16 while the first result waits
        //    (position frozen at row 2, col 3).
        run_a("t3", 12, 5, 17, 18, 21, 22, 23);

        // 4. last pixel taken at cycle 16, then sink stalls 17..20 in FLUSH.
        run_a("t4", 17, 4, 12, 13, 16, 21, 22);

        // 5. abort mid-frame with a result pending
        saw_done = 1'b0;
        hit = 0;
        a.out_ready = 1'b0;
        for (int cyc = 0; cyc < 30 && hit == 0; cyc++) begin
            a.start    = (cyc == 0);
            a.in_valid = 1'b1;
            @(negedge clk);
            if (a.done) saw_done = 1'b1;
            if (a.out_valid && a.row == 2 && a.col == 3) hit = 1;
            if (hit == 0) next_cycle();
        end
        check("t5 reached pending result", hit, 1);
        rst = 1'b1;
        #1;
        check("t5 rst in_ready", a.in_ready, 0);
        check("t5 rst shift_en", a.shift_en, 0);
        check("t5 rst busy", a.busy, 0);
        check("t5 rst out_valid", a.out_valid, 0);
        check("t5 rst done", a.done, 0);
        check("t5 rst row", a.row, 0);
        check("t5 rst col", a.col, 0);
        check("t5 rst out_cnt", a.out_cnt, 0);
        a.start = 1'b0; a.in_valid = 1'b0; a.out_ready = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (a.done) saw_done = 1'b1;
            next_cycle();
        end
        check("t5 no done on abort", saw_done, 0);
        run_a("t5 restart", 1000, 0, 12, 13, 16, 17, 18);

        // 6. 2x2 frame, 1x1 kernel; start re-asserted at cycles 2, 3, 6
        exp_sh    = 8'b0001_1110;
        exp_ov    = 8'b0011_1100;
        exp_dn    = 8'b0100_0000;
        start_pat = 8'b0100_1101;
        b.out_ready = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            b.start    = start_pat[cyc];
            b.in_valid = (cyc < 7);
            @(negedge clk);
            check($sformatf("t6 shift_en c%0d", cyc), b.shift_en, exp_sh[cyc]);
            check($sformatf("t6 out_valid c%0d", cyc), b.out_valid, exp_ov[cyc]);
            check($sformatf("t6 done c%0d", cyc), b.done, exp_dn[cyc]);
            if (cyc == 6) check("t6 out_cnt at done", b.out_cnt, 4);
            if (cyc == 7) check("t6 busy after", b.busy, 0);
            next_cycle();
        end
        b.start    = 1'b0;
        b.in_valid = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
